// File: rtl/svf_multi.sv
// Multi-channel Chamberlin state-variable filter sharing one external multiplier.
// Per-channel band/low integrators, saturating arithmetic, eight output modes.
module svf_multi #(
  parameter int DATA_W  = 14,
  parameter int STATE_W = 24,
  parameter int COEF_W  = 16,
  parameter int NUM_CH  = 3,
  parameter int F_FRAC  = 15,
  parameter int Q_FRAC  = 12,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                clear_i,
  input  logic [CH_W-1:0]                     ch_i,
  input  logic [2:0]                          filt_sel_i,
  input  logic signed [DATA_W-1:0]            wave_i,
  input  logic signed [COEF_W-1:0]            coeff_f_i,
  input  logic signed [COEF_W-1:0]            coeff_q_i,
  input  logic                                mult_ready_i,
  input  logic signed [STATE_W+COEF_W-1:0]    mult_prod_i,
  output logic signed [STATE_W-1:0]           mult_a_o,
  output logic signed [COEF_W-1:0]            mult_b_o,
  output logic                                mult_start_o,
  output logic                                busy_o,
  output logic                                ready_o,
  output logic [CH_W-1:0]                     ch_o,
  output logic signed [DATA_W-1:0]            wave_o
);

  // state     | meaning
  // IDLE      | waiting for start or clear
  // MULT_Q    | request band[ch] * q
  // WAIT_Q    | wait for damping product
  // CALC_HP   | hp = wave - low - qprod
  // MULT_F1   | request hp * f
  // WAIT_F1   | wait for first frequency product
  // CALC_BP   | bp = band + fprod, band updated
  // MULT_F2   | request bp * f
  // WAIT_F2   | wait for second frequency product
  // CALC_LP   | lp = low + fprod, low updated, output registered
  // DONE      | ready pulse

  localparam int SW2 = STATE_W + 2;
  localparam int PW  = STATE_W + COEF_W;

  typedef enum logic [3:0] {
    S_IDLE, S_MULT_Q, S_WAIT_Q, S_CALC_HP, S_MULT_F1, S_WAIT_F1,
    S_CALC_BP, S_MULT_F2, S_WAIT_F2, S_CALC_LP, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]            ch_q;
  logic [2:0]                 sel_q;
  logic signed [DATA_W-1:0]   wave_q;
  logic signed [COEF_W-1:0]   f_q;
  logic signed [COEF_W-1:0]   q_q;
  logic signed [STATE_W-1:0]  prod_q;
  logic signed [STATE_W-1:0]  hp_q;
  logic signed [STATE_W-1:0]  bp_q;
  logic signed [STATE_W-1:0]  band_q [NUM_CH];
  logic signed [STATE_W-1:0]  low_q  [NUM_CH];

  logic                       start_ok;
  logic signed [STATE_W-1:0]  band_cur;
  logic signed [STATE_W-1:0]  low_cur;
  logic signed [PW-1:0]       prod_sh;
  logic signed [STATE_W-1:0]  hp_next;
  logic signed [STATE_W-1:0]  bp_next;
  logic signed [STATE_W-1:0]  lp_next;
  logic signed [SW2-1:0]      mix;

  function automatic logic signed [STATE_W-1:0] sat_sum(input logic signed [SW2-1:0] v);
    logic [SW2-STATE_W:0] top;
    top = v[SW2-1:STATE_W-1];
    if ((&top) || (~|top)) return v[STATE_W-1:0];
    return v[SW2-1] ? {1'b1, {(STATE_W-1){1'b0}}} : {1'b0, {(STATE_W-1){1'b1}}};
  endfunction

  function automatic logic signed [STATE_W-1:0] sat_prod(input logic signed [PW-1:0] v);
    logic [PW-STATE_W:0] top;
    top = v[PW-1:STATE_W-1];
    if ((&top) || (~|top)) return v[STATE_W-1:0];
    return v[PW-1] ? {1'b1, {(STATE_W-1){1'b0}}} : {1'b0, {(STATE_W-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp_out(input logic signed [SW2-1:0] v);
    logic [SW2-DATA_W:0] top;
    top = v[SW2-1:DATA_W-1];
    if ((&top) || (~|top)) return v[DATA_W-1:0];
    return v[SW2-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign start_ok = start_i && !clear_i && (int'(ch_i) < NUM_CH);
  assign band_cur = band_q[ch_q];
  assign low_cur  = low_q[ch_q];
  assign busy_o   = (state_q != S_IDLE);
  assign ready_o  = (state_q == S_DONE);

  // Damping product uses Q4.12 scaling, both frequency products use Q1.15.
  always_comb begin
    prod_sh = (state_q == S_WAIT_Q) ? (mult_prod_i >>> Q_FRAC) : (mult_prod_i >>> F_FRAC);
  end

  always_comb begin
    hp_next = sat_sum(SW2'(wave_q) - SW2'(low_cur) - SW2'(prod_q));
    bp_next = sat_sum(SW2'(band_cur) + SW2'(prod_q));
    lp_next = sat_sum(SW2'(low_cur) + SW2'(prod_q));
  end

  always_comb begin
    mix = '0;
    if (sel_q == 3'b000) begin
      mix = SW2'(wave_q);
    end else begin
      if (sel_q[2]) mix = mix + SW2'(hp_q);
      if (sel_q[1]) mix = mix + SW2'(bp_q);
      if (sel_q[0]) mix = mix + SW2'(lp_next);
    end
  end

  always_comb begin
    mult_start_o = 1'b0;
    mult_a_o     = '0;
    mult_b_o     = '0;
    case (state_q)
      S_MULT_Q: begin
        mult_start_o = 1'b1;
        mult_a_o     = band_cur;
        mult_b_o     = q_q;
      end
      S_MULT_F1: begin
        mult_start_o = 1'b1;
        mult_a_o     = hp_q;
        mult_b_o     = f_q;
      end
      S_MULT_F2: begin
        mult_start_o = 1'b1;
        mult_a_o     = bp_q;
        mult_b_o     = f_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_MULT_Q;
      S_MULT_Q:  state_d = S_WAIT_Q;
      S_WAIT_Q:  if (mult_ready_i) state_d = S_CALC_HP;
      S_CALC_HP: state_d = S_MULT_F1;
      S_MULT_F1: state_d = S_WAIT_F1;
      S_WAIT_F1: if (mult_ready_i) state_d = S_CALC_BP;
      S_CALC_BP: state_d = S_MULT_F2;
      S_MULT_F2: state_d = S_WAIT_F2;
      S_WAIT_F2: if (mult_ready_i) state_d = S_CALC_LP;
      S_CALC_LP: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q   <= '0;
      sel_q  <= '0;
      wave_q <= '0;
      f_q    <= '0;
      q_q    <= '0;
      prod_q <= '0;
      hp_q   <= '0;
      bp_q   <= '0;
      ch_o   <= '0;
      wave_o <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        band_q[i] <= '0;
        low_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
              band_q[i] <= '0;
              low_q[i]  <= '0;
            end
          end else if (start_ok) begin
            ch_q   <= ch_i;
            sel_q  <= filt_sel_i;
            wave_q <= wave_i;
            f_q    <= coeff_f_i;
            q_q    <= coeff_q_i;
          end
        end
        S_WAIT_Q, S_WAIT_F1, S_WAIT_F2: begin
          if (mult_ready_i) prod_q <= sat_prod(prod_sh);
        end
        S_CALC_HP: hp_q <= hp_next;
        S_CALC_BP: begin
          bp_q         <= bp_next;
          band_q[ch_q] <= bp_next;
        end
        S_CALC_LP: begin
          low_q[ch_q] <= lp_next;
          wave_o      <= clamp_out(mix);
          ch_o        <= ch_q;
        end
        default: ;
      endcase
    end
  end

endmodule
